// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - handshake/bus bundle for one skid-buffered pipeline stage
interface pipe_stage_skid_if #(
    parameter int N  = 32,
    parameter int CW = 16
);
    logic [N-1:0]  In;
    logic          InValid;
    logic          InReady;
    logic          Flush;
    logic [N-1:0]  Out;
    logic          OutValid;
    logic          OutReady;
    logic [1:0]    Occupancy;
    logic [CW-1:0] StallCount;

    modport master (
        output In, InValid, Flush, OutReady,
        input  InReady, Out, OutValid, Occupancy, StallCount
    );

    modport slave (
        input  In, InValid, Flush, OutReady,
        output InReady, Out, OutValid, Occupancy, StallCount
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline register stage with 2-entry skid buffer, flush and stall counter
module pipe_stage_skid #(
    parameter int           N      = 32,
    parameter logic [N-1:0] BUBBLE = '0,
    parameter int           CW     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    pipe_stage_skid_if.slave bus
);
    // Encoding equals the number of held items, so it doubles as Occupancy.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]    state, state_d;
    logic [N-1:0]  main_q, main_d;
    logic [N-1:0]  skid_q, skid_d;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [CW-1:0] stall_q;
    logic          accept;
    logic          drain;

    assign accept = bus.InValid & in_ready_q;
    assign drain  = out_valid_q & bus.OutReady;

    always_comb begin
        state_d = state;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.Flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = bus.In;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_d = bus.In;
                    end else if (accept) begin
                        skid_d  = bus.In;
                        state_d = ST_FULL;
                    end else if (drain) begin
                        main_d  = BUBBLE;
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    // Handshake flags are registered from the next state so InReady never sees OutReady combinationally.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ST_EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_q <= '0;
        end else if (out_valid_q && !bus.OutReady && (stall_q != {CW{1'b1}})) begin
            stall_q <= stall_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign bus.Out        = main_q;
    assign bus.OutValid   = out_valid_q;
    assign bus.InReady    = in_ready_q;
    assign bus.Occupancy  = state;
    assign bus.StallCount = stall_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid against a FIFO reference
module tb_pipe_stage_skid;
    localparam int N  = 32;
    localparam int CW = 4;
    localparam logic [N-1:0] BUB = '0;
    localparam int STALL_MAX = (1 << CW) - 1;

    logic Clk;
    logic Reset;

    pipe_stage_skid_if #(.N(N), .CW(CW)) bus ();

    pipe_stage_skid #(.N(N), .BUBBLE(BUB), .CW(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    logic [N-1:0] exp_q[$];
    int exp_stall;
    int n_tests;
    int n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks state against the reference queue and pops on every drain.
    always @(negedge Clk) begin
        if (!Reset) begin
            check("occupancy", 64'(bus.Occupancy), 64'(exp_q.size()));
            check("out_valid", 64'(bus.OutValid), 64'(exp_q.size() > 0));
            check("in_ready", 64'(bus.InReady), 64'(exp_q.size() < 2));
            check("stall_count", 64'(bus.StallCount), 64'(exp_stall));
            if (!bus.OutValid)
                check("bubble_out", 64'(bus.Out), 64'(BUB));
            if (bus.OutValid && bus.OutReady && !bus.Flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_drain", 64'(1), 64'(0));
                end else begin
                    check("drain_data", 64'(bus.Out), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Reference update just before the edge: flush empties the FIFO, accepts are pushed.
    task automatic model_update();
        if (Reset) begin
            exp_q.delete();
            exp_stall = 0;
        end else begin
            if (bus.OutValid && !bus.OutReady && exp_stall < STALL_MAX)
                exp_stall++;
            if (bus.Flush)
                exp_q.delete();
            else if (bus.InValid && bus.InReady)
                exp_q.push_back(bus.In);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input logic iv, input logic [N-1:0] d, input logic ordy, input logic fl);
        bus.InValid  = iv;
        bus.In       = d;
        bus.OutReady = ordy;
        bus.Flush    = fl;
        #8;
        model_update();
        @(posedge Clk);
        #1;
    endtask

    task automatic sync_reset_pulse();
        bus.InValid = 1'b0;
        bus.Flush   = 1'b0;
        Reset       = 1'b1;
        #1;
        check("rst_stall_clear", 64'(bus.StallCount), 64'(0));
        check("rst_out", 64'(bus.Out), 64'(BUB));
        exp_q.delete();
        exp_stall = 0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_stall = 0;
        Reset = 1'b1;
        bus.InValid = 1'b0; bus.In = '0; bus.OutReady = 1'b0; bus.Flush = 1'b0;
        @(posedge Clk);
        #1;
        check("reset_occ", 64'(bus.Occupancy), 64'(0));
        check("reset_in_ready", 64'(bus.InReady), 64'(1));
        check("reset_out_valid", 64'(bus.OutValid), 64'(0));
        check("reset_out", 64'(bus.Out), 64'(BUB));
        Reset = 1'b0;

        // Stall counter saturation, survives flush, cleared by reset
        cycle(1'b1, 32'h77, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, '0, 1'b0, 1'b0);
        check("stall_saturated", 64'(bus.StallCount), 64'(15));
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("stall_after_flush", 64'(bus.StallCount), 64'(15));
        sync_reset_pulse();

        // Streaming at full rate
        cycle(1'b1, 32'h11, 1'b1, 1'b0);
        check("stream_first", 64'(bus.Out), 64'(32'h11));
        cycle(1'b1, 32'h22, 1'b1, 1'b0);
        check("stream_second", 64'(bus.Out), 64'(32'h22));
        cycle(1'b1, 32'h33, 1'b1, 1'b0);
        check("stream_third", 64'(bus.Out), 64'(32'h33));
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Backpressure into the skid entry
        cycle(1'b1, 32'hA, 1'b1, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        check("skid_full_occ", 64'(bus.Occupancy), 64'(2));
        check("skid_full_ready", 64'(bus.InReady), 64'(0));
        check("skid_full_out", 64'(bus.Out), 64'(32'hA));
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("skid_release_out", 64'(bus.Out), 64'(32'hB));
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("skid_empty_valid", 64'(bus.OutValid), 64'(0));
        check("skid_empty_out", 64'(bus.Out), 64'(BUB));

        // Flush while full with a pending input
        cycle(1'b1, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 32'h2, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b0, 1'b1);
        check("flush_occ", 64'(bus.Occupancy), 64'(0));
        check("flush_out", 64'(bus.Out), 64'(BUB));
        check("flush_ready", 64'(bus.InReady), 64'(1));
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle while full
        cycle(1'b1, 32'h5A, 1'b0, 1'b0);
        cycle(1'b1, 32'h6B, 1'b0, 1'b0);
        check("pre_async_occ", 64'(bus.Occupancy), 64'(2));
        bus.InValid = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check("async_occ", 64'(bus.Occupancy), 64'(0));
        check("async_valid", 64'(bus.OutValid), 64'(0));
        check("async_ready", 64'(bus.InReady), 64'(1));
        check("async_out", 64'(bus.Out), 64'(BUB));
        check("async_stall", 64'(bus.StallCount), 64'(0));
        exp_q.delete();
        exp_stall = 0;
        #3;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        cycle(1'b1, 32'h55, 1'b1, 1'b0);
        check("post_reset_out", 64'(bus.Out), 64'(32'h55));
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flush
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 5);
        end
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
        check("final_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the plain write-enabled pipeline register.
- One pipeline stage with a valid/ready handshake and a 2-entry skid buffer, so backpressure never forces a combinational ready path through the stage.
- Supports synchronous flush, which injects a bubble (NOP) value, and a saturating stall counter for performance debug.
- Sits between any two stages of the pipelined MIPS datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- N, 32, payload width in bits.
- BUBBLE, 0 (N bits), value driven on Out whenever OutValid=0, and the reset/flush value of both entries.
- CW, 16, width of the StallCount performance counter.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- In  input  N  upstream payload.
- InValid  input  1  upstream payload is valid.
- InReady  output  1  stage can accept; registered, depends only on state.
- Flush  input  1  synchronous flush; discards all held and incoming data.
- Out  output  N  downstream payload; equals BUBBLE when OutValid=0.
- OutValid  output  1  Out holds a valid item.
- OutReady  input  1  downstream accepts Out this cycle.
- Occupancy  output  2  number of held items, 0..2.
- StallCount  output  CW  cycles with OutValid=1 and OutReady=0; saturating.

Behaviour:
- Storage:
  - Main entry drives Out.
  - Skid entry catches the item accepted in the same cycle the downstream stalls.
- Transfer definitions:
  - Accept = InValid & InReady.
  - Drain = OutValid & OutReady.
- States:
  - EMPTY (Occupancy 0): OutValid=0, InReady=1.
  - ONE (Occupancy 1): OutValid=1, InReady=1.
  - FULL (Occupancy 2): OutValid=1, InReady=0.
- Transitions (no Flush):
  - EMPTY: Accept → main<=In, go ONE. Otherwise stay.
  - ONE: Accept & Drain → main<=In, stay ONE. Accept & !Drain → skid<=In, go FULL. !Accept & Drain → main<=BUBBLE, go EMPTY. Otherwise hold.
  - FULL: Drain → main<=skid, skid<=BUBBLE, go ONE. Otherwise hold. Accept is impossible because InReady=0.
- Latency and ordering:
  - Item accepted at edge t appears on Out with OutValid=1 after edge t, so it is drainable in cycle t+1.
  - Sustained throughput is 1 item/cycle while OutReady=1.
  - Strict FIFO order; no item is dropped or duplicated outside Flush.
- Out is a direct register output, never a combinational pass-through of In.
- Flush (highest priority after Reset):
  - At the edge where Flush=1: main<=BUBBLE, skid<=BUBBLE, go EMPTY.
  - Any concurrent Accept or Drain is ignored and the In item is lost.
  - A downstream that sampled Drain that cycle must itself honour Flush.
  - StallCount is unaffected by Flush.
- StallCount:
  - Increments at each edge where OutValid=1 & OutReady=0.
  - Saturates at 2^CW-1 and never wraps.
  - Cleared only by Reset.
- Reset (asynchronous, at any time, including mid-transfer):
  - Immediately: state EMPTY, main=skid=BUBBLE, Out=BUBBLE, OutValid=0, InReady=1, Occupancy=0, StallCount=0.
  - No transfer completes on an edge during which Reset is high.
- Out must never show skid contents while in state ONE.

Test Plan:
- Streaming: OutReady=1; feed 0x11,0x22,0x33 on consecutive cycles → Out shows 0x11,0x22,0x33 on the following consecutive cycles, Occupancy stays 1, InReady stays 1.
- Backpressure/skid: in ONE holding 0xA, drop OutReady while accepting 0xB → FULL, InReady=0, Out=0xA. Raise OutReady → Out=0xB next cycle, then EMPTY, with Out=BUBBLE and OutValid=0.
- Flush while FULL with InValid=1 and In=0xC → next cycle EMPTY, Out=0, OutValid=0, InReady=1; 0xC is never output.
- StallCount with CW=4: hold OutValid=1, OutReady=0 for 20 cycles → StallCount=15 and holds; Flush does not clear it; Reset clears it to 0.
- Async reset: assert Reset mid-cycle while FULL → outputs reach their reset values before the next Clk edge; after release, first accepted 0x55 emerges one cycle later.
- Random: random InValid/OutReady with 5% Flush over 10k cycles, scoreboard against a 2-deep FIFO model → every non-flushed item is output exactly once, in order; InReady equals (Occupancy<2).
